// File: rtl/hnf_txreq_sched_pkg.sv
// Shared CHI definitions for the HN-F TXREQ path: request flit layout and link-credit limit.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package hnf_txreq_sched_pkg;

  localparam int CHI_QOS_W    = 4;
  localparam int CHI_NODEID_W = 7;
  localparam int CHI_TXNID_W  = 8;
  localparam int CHI_OPCODE_W = 7;
  localparam int CHI_SIZE_W   = 3;
  localparam int CHI_ADDR_W   = 48;

  // Link-layer limit on outstanding L-credits per channel
  localparam int CHI_MAX_LCRD = 15;

  typedef struct packed {
    logic [CHI_QOS_W-1:0]    qos;
    logic [CHI_NODEID_W-1:0] tgt_id;
    logic [CHI_NODEID_W-1:0] src_id;
    logic [CHI_TXNID_W-1:0]  txn_id;
    logic [CHI_OPCODE_W-1:0] opcode;
    logic [CHI_SIZE_W-1:0]   size;
    logic [CHI_ADDR_W-1:0]   addr;
    logic                    ns;
    logic                    allow_retry;
    logic [1:0]              order;
    logic [3:0]              mem_attr;
  } reqflit_t;

  // Rewrites the identity fields that the home node owns on the way out
  function automatic reqflit_t stamp_flit(input reqflit_t             f,
                                          input [CHI_NODEID_W-1:0]    src,
                                          input [CHI_TXNID_W-1:0]     txn);
    reqflit_t o;
    o        = f;
    o.src_id = src;
    o.txn_id = txn;
    return o;
  endfunction

endpackage

// File: rtl/hnf_txreq_sched_if.sv
// Bundles the requester side and the CHI TXREQ link side of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: req_ready per requester; link flow control via TXREQLCRDV credits.
interface hnf_txreq_sched_if #(
  parameter int NUM_REQ = 2
);
  import hnf_txreq_sched_pkg::*;

  logic [NUM_REQ-1:0] req_valid;
  reqflit_t           req_flit [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  reqflit_t           TXREQFLIT;
  logic               TXREQFLITV;
  logic               TXREQFLITPEND;
  logic               TXREQLCRDV;

  // Driver of requests and credits (requesters + SNF)
  modport master (
    output req_valid, req_flit, TXREQLCRDV,
    input  req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
  );

  // The scheduler itself
  modport slave (
    input  req_valid, req_flit, TXREQLCRDV,
    output req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
  );

endinterface

// File: rtl/hnf_txreq_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among set req bits, searching from the pointer.
// Latency: grant is combinational; pointer updates one cycle after an advance.
// Backpressure: pointer only moves when advance (grant accepted) is high.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_gidx;
  logic [PW-1:0] w_next;

  // Pick the first requester at or after the pointer; scanning downward lets the nearest win
  always_comb begin
    grant  = '0;
    w_idx  = '0;
    w_gidx = r_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % N);
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        w_gidx       = w_idx;
      end
    end
    w_next = (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
  end

  // Pointer moves past the granted requester only when the grant is taken
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/hnf_txreq_sched.sv
// Arbitrates internal requesters onto the CHI TXREQ channel, gated by held L-credits.
// Latency: 1 cycle from acceptance to TXREQFLITV (registered flit).
// Backpressure: req_ready is zero while no credit is held; one flit per cycle otherwise.
module hnf_txreq_sched
  import hnf_txreq_sched_pkg::*;
#(
  parameter int         NUM_REQ = 2,
  parameter int         MAX_CRD = CHI_MAX_LCRD,
  parameter logic [6:0] HN_ID   = 7'd0
) (
  input  logic                           clock,
  input  logic                           reset,
  hnf_txreq_sched_if.slave               bus,
  output logic [$clog2(MAX_CRD+1)-1:0]   crd_cnt,
  output logic                           crd_ovf
);

  localparam int CW = $clog2(MAX_CRD + 1);

  logic [CW-1:0]          r_crd;
  logic                   r_ovf;
  reqflit_t               r_flit;
  logic                   r_flit_vld;
  logic [CHI_TXNID_W-1:0] r_txnid;

  logic                   w_crd_nz;
  logic [NUM_REQ-1:0]     w_req;
  logic [NUM_REQ-1:0]     w_grant;
  logic                   w_acc;
  reqflit_t               w_sel;

  // A credit arriving this cycle is not visible here until it lands in r_crd
  assign w_crd_nz = (r_crd != '0);
  assign w_req    = bus.req_valid & {NUM_REQ{w_crd_nz}};
  assign w_acc    = |(bus.req_valid & w_grant);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (w_req),
    .advance (w_acc),
    .grant   (w_grant)
  );

  // Select the granted requester's flit (grant is one-hot or zero)
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel = bus.req_flit[i];
    end
  end

  // Credit bookkeeping: return and spend in one cycle cancel; a return at the limit is an error
  always_ff @(posedge clock) begin
    if (reset) begin
      r_crd <= '0;
      r_ovf <= 1'b0;
    end else begin
      case ({bus.TXREQLCRDV, w_acc})
        2'b10: begin
          if (r_crd == CW'(MAX_CRD)) r_ovf <= 1'b1;
          else                       r_crd <= r_crd + 1'b1;
        end
        2'b01:   r_crd <= r_crd - 1'b1;
        default: r_crd <= r_crd;
      endcase
    end
  end

  // Output flit register; holds its contents when nothing new is sent
  always_ff @(posedge clock) begin
    if (reset) begin
      r_flit     <= '0;
      r_flit_vld <= 1'b0;
      r_txnid    <= '0;
    end else begin
      r_flit_vld <= w_acc;
      if (w_acc) begin
        r_flit  <= stamp_flit(w_sel, HN_ID, r_txnid);
        r_txnid <= r_txnid + 1'b1;
      end
    end
  end

  assign bus.req_ready     = w_grant;
  assign bus.TXREQFLIT     = r_flit;
  assign bus.TXREQFLITV    = r_flit_vld;
  assign bus.TXREQFLITPEND = |bus.req_valid;
  assign crd_cnt           = r_crd;
  assign crd_ovf           = r_ovf;

endmodule

// File: doc/hnf_txreq_sched.md
HNF_TXREQ_SCHED -- requirements
Module: hnf_txreq_sched

Interface
REQ-001 Parameter: NUM_REQ, default 2, number of internal requesters sharing the TXREQ channel.
REQ-002 Parameter: MAX_CRD, default 15, maximum L-credits the block can hold (CHI limit).
REQ-003 Parameter: HN_ID, default 0, 7-bit node ID stamped into SrcID.
REQ-004 clock  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester flit valid.
REQ-007 req_flit  input  NUM_REQ x reqflit_t  per-requester request flit.
REQ-008 req_ready  output  NUM_REQ  one-hot grant; flit accepted when req_valid[i] & req_ready[i].
REQ-009 TXREQFLIT  output  reqflit_t  flit to SNF.
REQ-010 TXREQFLITV  output  1  flit valid.
REQ-011 TXREQFLITPEND  output  1  flit-pending early indication.
REQ-012 TXREQLCRDV  input  1  L-credit return from SNF, one credit per cycle asserted.
REQ-013 crd_cnt  output  $clog2(MAX_CRD+1)  current held credits.
REQ-014 crd_ovf  output  1  sticky credit-overflow error.

Function
REQ-015 Credit counter: +1 on TXREQLCRDV, -1 on accepted flit; both in the same cycle leaves it unchanged.
REQ-016 A grant SHALL issue only when crd_cnt > 0; a credit arriving in the same cycle does not enable a grant until the next cycle.
REQ-017 TXREQLCRDV with crd_cnt == MAX_CRD and no same-cycle send: count held, crd_ovf set until reset.
REQ-018 Arbitration: round-robin over requesters with req_valid set; the pointer moves to the requester after the last granted one, and only on an accepted grant.
REQ-019 req_ready SHALL be at most one-hot, combinational from req_valid, the pointer and crd_cnt; all zero when crd_cnt == 0.
REQ-020 Accepted flit SHALL appear on TXREQFLIT with TXREQFLITV = 1 exactly one cycle after acceptance (registered, latency 1).
REQ-021 Outgoing flit fields SHALL be copied from req_flit, except SrcID = HN_ID and TxnID = internal 8-bit counter.
REQ-022 TxnID counter increments per accepted flit and wraps 255 -> 0.
REQ-023 TXREQFLITV SHALL be 0 in any cycle without a prior-cycle acceptance; TXREQFLIT holds its last value when TXREQFLITV = 0.
REQ-024 TXREQFLITPEND = |req_valid (combinational), so it is high at least one cycle before the corresponding TXREQFLITV.
REQ-025 Back-to-back: one flit per cycle is sustained while credits > 0 and requests pending.

Reset
REQ-026 On reset: crd_cnt = 0, crd_ovf = 0, TXREQFLITV = 0, TXREQFLIT = '0, TxnID counter = 0, RR pointer = requester 0.
REQ-027 Reset mid-operation: an in-flight registered flit is discarded (TXREQFLITV = 0 next cycle) and credits are lost; TXREQLCRDV during reset is ignored.

Structure
REQ-028 reqflit_t, CHI field widths and the MAX_CRD default SHALL live in the shared CHI package; no local redefinition.
REQ-029 A sub-module rr_arbiter (parameter N; inputs req and advance; output one-hot grant) SHALL hold the round-robin logic.

Verification
REQ-030 Reset, then 3 TXREQLCRDV pulses -> crd_cnt = 3 and no TXREQFLITV without requests.
REQ-031 crd_cnt = 2, req_valid = 2'b11 held for 4 cycles -> grants go 0 then 1; two TXREQFLITV pulses with TxnID 0 and 1; then req_ready = 0 and crd_cnt = 0.
REQ-032 crd_cnt = 1, flit accepted while TXREQLCRDV = 1 in the same cycle -> crd_cnt stays 1 and the next grant follows.
REQ-033 16 credit pulses with no traffic -> crd_cnt = 15 and crd_ovf = 1, held until reset.
REQ-034 Send 257 flits -> the 257th has TxnID 0 and every flit's SrcID equals HN_ID.
REQ-035 Reset asserted the cycle after acceptance -> TXREQFLITV = 0 and crd_cnt = 0 in the following cycle.
